// File: rtl/cpu6502_serial_alu_pkg.sv
// Shared ALU operation codes, flag positions and serial-ALU state encodings
// for the byte-serial 6502-family ALU.
package cpu6502_serial_alu_pkg;

    localparam logic [2:0] ALU_OP_ADC    = 3'd0;
    localparam logic [2:0] ALU_OP_SBC    = 3'd1;
    localparam logic [2:0] ALU_OP_AND    = 3'd2;
    localparam logic [2:0] ALU_OP_OR     = 3'd3;
    localparam logic [2:0] ALU_OP_EOR    = 3'd4;
    localparam logic [2:0] ALU_OP_SGL    = 3'd5;
    localparam logic [2:0] ALU_OP_SETBIT = 3'd6;
    localparam logic [2:0] ALU_OP_CLRBIT = 3'd7;

    localparam logic [2:0] ALU_SOP_ASL    = 3'd0;
    localparam logic [2:0] ALU_SOP_LSR    = 3'd1;
    localparam logic [2:0] ALU_SOP_ROL    = 3'd2;
    localparam logic [2:0] ALU_SOP_ROR    = 3'd3;
    localparam logic [2:0] ALU_SOP_TEST_Z = 3'd4;
    localparam logic [2:0] ALU_SOP_TEST_N = 3'd5;

    localparam int FLAG_C = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_I = 2;
    localparam int FLAG_D = 3;
    localparam int FLAG_V = 6;
    localparam int FLAG_N = 7;

    typedef enum logic [1:0] {
        ALU_SER_IDLE = 2'd0,
        ALU_SER_RUN  = 2'd1,
        ALU_SER_DONE = 2'd2
    } alu_ser_state_t;

    function automatic logic is_arith(input logic [2:0] op);
        return (op == ALU_OP_ADC) || (op == ALU_OP_SBC);
    endfunction

    function automatic logic is_shift(input logic [2:0] op, input logic [2:0] ext);
        return (op == ALU_OP_SGL) && (ext <= ALU_SOP_ROR);
    endfunction

    // Right shifts walk from the most significant processed byte downward.
    function automatic logic is_down(input logic [2:0] op, input logic [2:0] ext);
        return (op == ALU_OP_SGL) && ((ext == ALU_SOP_LSR) || (ext == ALU_SOP_ROR));
    endfunction

    function automatic logic chain_seed(input logic [2:0] op, input logic [2:0] ext,
                                        input logic cin);
        if ((op == ALU_OP_SGL) && ((ext == ALU_SOP_ASL) || (ext == ALU_SOP_LSR))) begin
            return 1'b0;
        end else begin
            return cin;
        end
    endfunction

endpackage

// File: rtl/cpu6502_serial_alu_byte_alu.sv
// Combinational one-byte ALU slice; the serial top feeds it one byte per clock
// and chains carry between slices.
module cpu6502_byte_alu
    import cpu6502_serial_alu_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       chain_in,
    input  logic [2:0] op,
    input  logic [2:0] ext,
    input  logic       decimal,
    input  logic       first_byte,
    output logic [7:0] result_byte,
    output logic       chain_out,
    output logic       byte_overflow
);

    logic       subtract_s;
    logic [7:0] bb_s;
    logic [8:0] bin_sum_s;
    logic [4:0] lo_s;
    logic [4:0] hi_s;
    logic       half_s;
    logic       dec_carry_s;
    logic [3:0] lo_adj_s;
    logic [3:0] hi_adj_s;
    logic [7:0] mask_s;

    // BCD correction: add fixes digits above 9, subtract fixes digits that borrowed.
    always_comb begin
        subtract_s = (op == ALU_OP_SBC);
        bb_s       = subtract_s ? ~b : b;
        bin_sum_s  = {1'b0, a} + {1'b0, bb_s} + {8'd0, chain_in};
        lo_s       = {1'b0, a[3:0]} + {1'b0, bb_s[3:0]} + {4'd0, chain_in};
        if (subtract_s) begin
            half_s   = lo_s[4];
            lo_adj_s = half_s ? lo_s[3:0] : (lo_s[3:0] + 4'd10);
        end else begin
            half_s   = (lo_s > 5'd9);
            lo_adj_s = half_s ? (lo_s[3:0] + 4'd6) : lo_s[3:0];
        end
        hi_s = {1'b0, a[7:4]} + {1'b0, bb_s[7:4]} + {4'd0, half_s};
        if (subtract_s) begin
            dec_carry_s = hi_s[4];
            hi_adj_s    = dec_carry_s ? hi_s[3:0] : (hi_s[3:0] + 4'd10);
        end else begin
            dec_carry_s = (hi_s > 5'd9);
            hi_adj_s    = dec_carry_s ? (hi_s[3:0] + 4'd6) : hi_s[3:0];
        end
        mask_s = 8'd1 << ext;
    end

    // Operation select for this byte.
    always_comb begin
        result_byte   = a;
        chain_out     = chain_in;
        byte_overflow = (a[7] == bb_s[7]) && (bin_sum_s[7] != a[7]);
        case (op)
            ALU_OP_ADC, ALU_OP_SBC: begin
                if (decimal) begin
                    result_byte = {hi_adj_s, lo_adj_s};
                    chain_out   = dec_carry_s;
                end else begin
                    result_byte = bin_sum_s[7:0];
                    chain_out   = bin_sum_s[8];
                end
            end
            ALU_OP_AND: result_byte = a & b;
            ALU_OP_OR:  result_byte = a | b;
            ALU_OP_EOR: result_byte = a ^ b;
            ALU_OP_SGL: begin
                case (ext)
                    ALU_SOP_ASL, ALU_SOP_ROL: begin
                        result_byte = {a[6:0], chain_in};
                        chain_out   = a[7];
                    end
                    ALU_SOP_LSR, ALU_SOP_ROR: begin
                        result_byte = {chain_in, a[7:1]};
                        chain_out   = a[0];
                    end
                    default: result_byte = a;
                endcase
            end
            ALU_OP_SETBIT: result_byte = first_byte ? (a | mask_s) : a;
            ALU_OP_CLRBIT: result_byte = first_byte ? (a & ~mask_s) : a;
            default:       result_byte = a;
        endcase
    end

endmodule

// File: rtl/cpu6502_serial_alu.sv
// Byte-serial ALU top: start/ready handshake, one byte per clock, registered
// result and flags with a one-cycle done pulse.
module cpu6502_serial_alu
    import cpu6502_serial_alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             ready,
    input  logic [WIDTH-1:0] operandA,
    input  logic [WIDTH-1:0] operandB,
    input  logic             carryIn,
    input  logic             overflowIn,
    input  logic [2:0]       operation,
    input  logic [2:0]       opExtension,
    input  logic             decimalMode,
    input  logic             shortMode,
    output logic [WIDTH-1:0] result,
    output logic             carryOut,
    output logic             overflowOut,
    output logic             zero,
    output logic             negative,
    output logic             done
);

    localparam int BYTES = WIDTH / 8;
    localparam int IDXW  = (BYTES > 1) ? $clog2(BYTES) : 1;

    alu_ser_state_t   state_r;
    logic [IDXW-1:0]  idx_r;
    logic [IDXW-1:0]  last_r;
    logic [WIDTH-1:0] work_r;
    logic [WIDTH-1:0] b_r;
    logic [2:0]       op_r;
    logic [2:0]       ext_r;
    logic             dec_r;
    logic             down_r;
    logic             cin_r;
    logic             vin_r;
    logic             chain_r;
    logic             zacc_r;

    logic [IDXW-1:0]  sel_s;
    logic [7:0]       a_byte_s;
    logic [7:0]       b_byte_s;
    logic [7:0]       byte_s;
    logic             chain_out_s;
    logic             byte_ovf_s;
    logic [WIDTH-1:0] next_work_s;

    // Pick the byte lane for this step and splice the slice output back in.
    always_comb begin
        sel_s       = down_r ? (last_r - idx_r) : idx_r;
        a_byte_s    = work_r[{sel_s, 3'b000} +: 8];
        b_byte_s    = b_r[{sel_s, 3'b000} +: 8];
        next_work_s = work_r;
        next_work_s[{sel_s, 3'b000} +: 8] = byte_s;
    end

    cpu6502_byte_alu u_byte_alu (
        .a             (a_byte_s),
        .b             (b_byte_s),
        .chain_in      (chain_r),
        .op            (op_r),
        .ext           (ext_r),
        .decimal       (dec_r),
        .first_byte    (sel_s == '0),
        .result_byte   (byte_s),
        .chain_out     (chain_out_s),
        .byte_overflow (byte_ovf_s)
    );

    // Handshake FSM, byte stepping and registered completion outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ALU_SER_IDLE;
            ready       <= 1'b1;
            done        <= 1'b0;
            result      <= '0;
            carryOut    <= 1'b0;
            overflowOut <= 1'b0;
            zero        <= 1'b0;
            negative    <= 1'b0;
            idx_r       <= '0;
            last_r      <= '0;
            work_r      <= '0;
            b_r         <= '0;
            op_r        <= 3'd0;
            ext_r       <= 3'd0;
            dec_r       <= 1'b0;
            down_r      <= 1'b0;
            cin_r       <= 1'b0;
            vin_r       <= 1'b0;
            chain_r     <= 1'b0;
            zacc_r      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_r)
                ALU_SER_IDLE, ALU_SER_DONE: begin
                    if (start) begin
                        state_r <= ALU_SER_RUN;
                        ready   <= 1'b0;
                        idx_r   <= '0;
                        last_r  <= shortMode ? '0 : IDXW'(BYTES - 1);
                        work_r  <= operandA;
                        b_r     <= operandB;
                        op_r    <= operation;
                        ext_r   <= opExtension;
                        dec_r   <= decimalMode;
                        down_r  <= is_down(operation, opExtension);
                        cin_r   <= carryIn;
                        vin_r   <= overflowIn;
                        chain_r <= chain_seed(operation, opExtension, carryIn);
                        zacc_r  <= 1'b1;
                    end else begin
                        state_r <= ALU_SER_IDLE;
                        ready   <= 1'b1;
                    end
                end
                ALU_SER_RUN: begin
                    work_r  <= next_work_s;
                    chain_r <= chain_out_s;
                    zacc_r  <= zacc_r & (byte_s == 8'd0);
                    if (idx_r == last_r) begin
                        state_r     <= ALU_SER_DONE;
                        ready       <= 1'b1;
                        done        <= 1'b1;
                        result      <= next_work_s;
                        carryOut    <= (is_arith(op_r) || is_shift(op_r, ext_r)) ? chain_out_s : cin_r;
                        overflowOut <= is_arith(op_r) ? byte_ovf_s : vin_r;
                        zero        <= zacc_r & (byte_s == 8'd0);
                        negative    <= next_work_s[{last_r, 3'b111}];
                    end else begin
                        idx_r <= idx_r + IDXW'(1);
                    end
                end
                default: begin
                    state_r <= ALU_SER_IDLE;
                    ready   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu6502_serial_alu.sv
// Directed self-checking bench for the byte-serial ALU at WIDTH=16.
module tb_cpu6502_serial_alu;
    import cpu6502_serial_alu_pkg::*;

    logic        clk;
    logic        reset;
    logic        start;
    logic        ready;
    logic [15:0] operandA;
    logic [15:0] operandB;
    logic        carryIn;
    logic        overflowIn;
    logic [2:0]  operation;
    logic [2:0]  opExtension;
    logic        decimalMode;
    logic        shortMode;
    logic [15:0] result;
    logic        carryOut;
    logic        overflowOut;
    logic        zero;
    logic        negative;
    logic        done;

    int tests = 0;
    int fails = 0;
    int lat   = 0;
    logic seen_done;

    cpu6502_serial_alu #(.WIDTH(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .ready       (ready),
        .operandA    (operandA),
        .operandB    (operandB),
        .carryIn     (carryIn),
        .overflowIn  (overflowIn),
        .operation   (operation),
        .opExtension (opExtension),
        .decimalMode (decimalMode),
        .shortMode   (shortMode),
        .result      (result),
        .carryOut    (carryOut),
        .overflowOut (overflowOut),
        .zero        (zero),
        .negative    (negative),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic launch(input logic [2:0] op, input logic [2:0] ext, input logic [15:0] a,
                          input logic [15:0] b, input logic cin, input logic vin,
                          input logic dec, input logic sh);
        operation   = op;
        opExtension = ext;
        operandA    = a;
        operandB    = b;
        carryIn     = cin;
        overflowIn  = vin;
        decimalMode = dec;
        shortMode   = sh;
        start       = 1'b1;
    endtask

    // Accept edge, then count edges until done (bounded).
    task automatic finish_op(input string tag);
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, "_ready_low"}, {31'd0, ready}, 32'd0);
        lat = 0;
        while (done !== 1'b1 && lat < 8) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic expect_out(input string tag, input logic [15:0] res, input logic c,
                              input logic v, input logic z, input logic n, input int elat);
        chk({tag, "_latency"}, lat, elat);
        chk({tag, "_result"}, {16'd0, result}, {16'd0, res});
        chk({tag, "_C"}, {31'd0, carryOut}, {31'd0, c});
        chk({tag, "_V"}, {31'd0, overflowOut}, {31'd0, v});
        chk({tag, "_Z"}, {31'd0, zero}, {31'd0, z});
        chk({tag, "_N"}, {31'd0, negative}, {31'd0, n});
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        operandA = 16'h0000; operandB = 16'h0000;
        carryIn = 1'b0; overflowIn = 1'b0;
        operation = ALU_OP_ADC; opExtension = 3'd0;
        decimalMode = 1'b0; shortMode = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", {31'd0, ready}, 32'd1);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_result", {16'd0, result}, 32'd0);
        chk("rst_flags", {28'd0, carryOut, overflowOut, zero, negative}, 32'd0);
        reset = 1'b0;

        @(negedge clk); launch(ALU_OP_ADC, 3'd0, 16'h12FF, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0);
        finish_op("adc_bin");
        expect_out("adc_bin", 16'h1300, 1'b0, 1'b0, 1'b0, 1'b0, 2);

        @(negedge clk); launch(ALU_OP_ADC, 3'd0, 16'h0999, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b0);
        finish_op("adc_dec1");
        expect_out("adc_dec1", 16'h1000, 1'b0, 1'b0, 1'b0, 1'b0, 2);

        @(negedge clk); launch(ALU_OP_ADC, 3'd0, 16'h9999, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b0);
        finish_op("adc_dec2");
        expect_out("adc_dec2", 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 2);

        @(negedge clk); launch(ALU_OP_SBC, 3'd0, 16'h0000, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0);
        finish_op("sbc_wrap");
        expect_out("sbc_wrap", 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1, 2);

        @(negedge clk); launch(ALU_OP_SBC, 3'd0, 16'h8000, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0);
        finish_op("sbc_ovf");
        expect_out("sbc_ovf", 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0, 2);

        @(negedge clk); launch(ALU_OP_SGL, ALU_SOP_LSR, 16'h0101, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
        finish_op("lsr");
        expect_out("lsr", 16'h0080, 1'b1, 1'b0, 1'b0, 1'b0, 2);

        @(negedge clk); launch(ALU_OP_SGL, ALU_SOP_ROR, 16'h0002, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
        finish_op("ror");
        expect_out("ror", 16'h8001, 1'b0, 1'b0, 1'b0, 1'b1, 2);

        @(negedge clk); launch(ALU_OP_SGL, ALU_SOP_ASL, 16'h8080, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
        finish_op("asl");
        expect_out("asl", 16'h0100, 1'b1, 1'b0, 1'b0, 1'b0, 2);

        @(negedge clk); launch(ALU_OP_AND, 3'd0, 16'hF0F0, 16'h3C3C, 1'b1, 1'b0, 1'b0, 1'b0);
        finish_op("and");
        expect_out("and", 16'h3030, 1'b1, 1'b0, 1'b0, 1'b0, 2);

        @(negedge clk); launch(ALU_OP_EOR, 3'd0, 16'h8001, 16'h8001, 1'b0, 1'b1, 1'b0, 1'b0);
        finish_op("eor");
        expect_out("eor", 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 2);

        @(negedge clk); launch(ALU_OP_ADC, 3'd0, 16'h12FF, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b1);
        finish_op("adc_short");
        expect_out("adc_short", 16'h1200, 1'b1, 1'b0, 1'b1, 1'b0, 1);
        // Back-to-back: start raised while done is high.
        launch(ALU_OP_SETBIT, 3'd3, 16'h3400, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1);
        finish_op("setbit_b2b");
        expect_out("setbit_b2b", 16'h3408, 1'b1, 1'b1, 1'b0, 1'b0, 1);

        // Start during RUN is ignored and not queued.
        @(negedge clk); launch(ALU_OP_ADC, 3'd0, 16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk("busy_ready_low", {31'd0, ready}, 32'd0);
        launch(ALU_OP_ADC, 3'd0, 16'h0F0F, 16'h0101, 1'b1, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        chk("busy_done", {31'd0, done}, 32'd1);
        chk("busy_result", {16'd0, result}, 32'h0000_3333);
        @(posedge clk); #1;
        chk("busy_not_queued_ready", {31'd0, ready}, 32'd1);
        chk("busy_not_queued_done", {31'd0, done}, 32'd0);

        // Reset mid-RUN aborts without completion.
        @(negedge clk); launch(ALU_OP_ADC, 3'd0, 16'h1111, 16'h2222, 1'b1, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        start = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort_ready", {31'd0, ready}, 32'd1);
        chk("abort_result", {16'd0, result}, 32'd0);
        chk("abort_carry", {31'd0, carryOut}, 32'd0);
        seen_done = done;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            seen_done = seen_done | done;
        end
        chk("abort_no_done", {31'd0, seen_done}, 32'd0);

        // Start coincident with reset: reset wins.
        @(negedge clk);
        reset = 1'b1;
        launch(ALU_OP_ADC, 3'd0, 16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;
        start = 1'b0;
        chk("rst_start_ready", {31'd0, ready}, 32'd1);
        @(posedge clk); #1;
        chk("rst_start_idle", {30'd0, ready, done}, 32'd2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cpu6502_serial_alu.md
# cpu6502_serial_alu

Byte-serial, width-parametrised successor to the 8-bit 6502 ALU, for the 65C816-class core and wider datapaths. It accepts one operation through a start/ready handshake and processes one byte per clock, chaining carry (binary or BCD) between bytes. It raises a one-cycle `done` with registered result and flags. It sits between the microcode sequencer and the register file; the sequencer stalls on `ready`.

## Interface
- `WIDTH`, default 16: datapath width; multiple of 8, ≥ 8. `BYTES = WIDTH/8` is derived, not settable.
- `clk`  in  1: sole clock, rising edge.
- `reset`  in  1: synchronous, active-high.
- `start`  in  1: request; accepted only when `ready`=1.
- `ready`  out  1: may accept `start` this cycle.
- `operandA`, `operandB`  in  WIDTH: operands, sampled at accept.
- `carryIn`, `overflowIn`  in  1: incoming C/V, sampled at accept.
- `operation`  in  3: ALU_OP_* code.
- `opExtension`  in  3: ALU_SOP_* code, or bit index for SETBIT/CLRBIT.
- `decimalMode`  in  1: BCD add/subtract.
- `shortMode`  in  1: operate on low byte only; 65816 M=1 behaviour.
- `result`  out  WIDTH: registered result.
- `carryOut`, `overflowOut`, `zero`, `negative`  out  1: registered flags.
- `done`  out  1: one-cycle pulse; outputs are valid from this cycle.

## Operation
- States: IDLE, RUN, DONE.
  - IDLE→RUN on `start`.
  - RUN→DONE after the last byte.
  - DONE→RUN on `start`; otherwise DONE→IDLE.
- `ready` = 1 in IDLE and DONE, 0 in RUN.
- Accept latches all inputs. `n` = 1 if `shortMode`, else BYTES. Input changes during RUN are ignored.
- Processing order:
  - ADC, SBC, ASL, ROL, logic ops: byte 0 upward.
  - LSR, ROR: byte n−1 downward.
- Carry chain register starts at the latched `carryIn` (ROL/ROR/ADC/SBC) or 0 (ASL/LSR). Each byte's carry-out feeds the next byte.
- ADC/SBC: SBC adds ~B. Per-byte decimal correction is identical to the 8-bit ALU: low nibble +6 on half-carry for add, +10 on no half-carry for subtract; high nibble likewise. Non-BCD digits give that same deterministic result.
- AND/OR/EOR: bytewise; C and V pass through.
- SETBIT/CLRBIT: byte 0 only.
- SGL TEST_* and undefined codes: result = operandA; C and V pass through.
- `shortMode`: result bytes 1..BYTES−1 = latched operandA bytes, unmodified.
- Flags at completion, over processed bytes only:
  - `zero`: all processed bytes are 0.
  - `negative`: bit 7 of byte n−1.
  - `overflowOut`: ADC/SBC signed overflow of byte n−1; otherwise `overflowIn`.
  - `carryOut`: final chain value for arithmetic and shifts; otherwise `carryIn`.
- Outputs hold until the next completion.

## Timing
- Accept at edge 0. Byte i is processed at edge i+1. `done` is high in the cycle after edge n, so latency is n cycles.
  - WIDTH=16: 2 cycles full, 1 cycle short.
- Back-to-back: `start` during DONE is accepted, giving throughput of one op per n cycles.
- Reset values: state IDLE, `ready`=1, `done`=0, `result`=0, all flags 0.
- Reset during RUN aborts with no completion and no flag update. The result register is cleared to 0.
- `start` together with `reset`: reset wins.
- `start` while `ready`=0: ignored and not queued.

## Structure
- Shared header `Cpu6502MicrocodeConstants.vh` holds:
  - the existing ALU_OP_* and ALU_SOP_* codes and flag bit positions;
  - new state encodings ALU_SER_IDLE, ALU_SER_RUN, ALU_SER_DONE.
- Sub-module `cpu6502_byte_alu`: combinational one-byte slice.
  - Inputs: a, b, chainIn, op, ext, decimal, byteIndex==0.
  - Outputs: byte, chainOut, byteOverflow.
- Top level holds the FSM, byte index counter, latched operands and result shift register.

## Test plan
- ADC, WIDTH=16, binary, 0x12FF+0x0001, C=0 → 0x1300, C=0, Z=0, N=0, V=0; `done` 2 cycles after accept.
- ADC decimal: 0x0999+0x0001, C=0 → 0x1000, C=0; 0x9999+0x0001 → 0x0000, C=1, Z=1.
- SBC binary: 0x0000−0x0001, C=1 → 0xFFFF, C=0, N=1, V=0; 0x8000−0x0001, C=1 → 0x7FFF, C=1, V=1.
- Shifts: LSR 0x0101 → 0x0080, C=1; ROR 0x0002 with C=1 → 0x8001, C=0; ASL 0x8080 → 0x0100, C=1.
- shortMode ADC 0x12FF+0x0001 → 0x1200, C=1, Z=1; `done` 1 cycle after accept; back-to-back `start` in DONE accepted.
- Reset asserted mid-RUN → next cycle `ready`=1, `done` never pulses, `result`=0; `start` during RUN ignored and operands unchanged.
